corona_spawn_scheduler: RTL and testbench
=========================================

# corona_spawn_scheduler

Sequences corona respawning for the corona position datapath during the second game phase. It tracks which of the corona slots are alive and runs a per-slot respawn cooldown counted in video frames. It picks the next free slot round-robin and samples the random generator until it gets an in-bounds position, then offers one spawn per frame to the position register through a valid/ready handshake.

## Interface
- NUM_SLOTS, 10: number of corona slots.
- RESPAWN_FRAMES, 60: frames a killed slot stays dead before it may respawn.
- MAX_RETRY, 7: out-of-bounds resamples before the position is clamped.
- X_MIN / X_MAX, 32 / 575: legal spawn X range, inclusive.
- Y_MIN / Y_MAX, 64 / 415: legal spawn Y range, inclusive.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start_of_frame  in  1  one-cycle pulse per video frame.
- enable  in  1  spawning permitted (phase 2 active).
- kill_valid  in  1  clamp/corona collision event.
- kill_index  in  4  killed slot; values ≥ NUM_SLOTS (15 = none) are ignored.
- rand_x, rand_y  in  11 each  free-running random coordinates.
- spawn_ready  in  1  position register accepts the offer.
- spawn_valid  out  1  spawn offer pending.
- spawn_index  out  4  slot being spawned.
- spawn_x, spawn_y  out  11 each  top-left of the new corona.
- alive  out  NUM_SLOTS  per-slot alive (draw) vector.
- alive_count  out  4  popcount of alive.

## Operation
- Per-slot state: alive bit and a cooldown counter of width clog2(RESPAWN_FRAMES+1). A slot is eligible when alive=0 and cooldown=0.
- Kill: kill_valid with a legal index of an alive slot sets alive←0 and cooldown←RESPAWN_FRAMES. A kill of a dead or pending slot, or an illegal index, is ignored; it does not restart the cooldown.
- Cooldown: each start_of_frame decrements every nonzero cooldown of a dead slot. The counter saturates at 0. If a kill and start_of_frame hit the same slot in the same cycle, the kill load wins.
- FSM states: IDLE, SAMPLE, CHECK, OFFER, GAP.
  - IDLE: when enable=1 and any slot is eligible, latch slot = the first eligible slot searching from (rr_ptr+1) mod NUM_SLOTS, clear retry, go to SAMPLE.
  - SAMPLE: latch rand_x and rand_y, go to CHECK.
  - CHECK: if both coordinates are in range, go to OFFER. Else, if retry < MAX_RETRY, increment retry and go to SAMPLE. Else clamp each coordinate into [MIN, MAX] (unsigned compare) and go to OFFER.
  - OFFER: spawn_valid=1, with index, x and y stable. On spawn_valid & spawn_ready: alive[slot]←1, rr_ptr←slot, go to GAP. An offer is never withdrawn, even if enable drops.
  - GAP: wait for start_of_frame, then go to IDLE. This limits spawning to at most one per frame.
- A kill of a different slot in the handshake cycle applies together with the spawn.
- enable=0 only blocks IDLE→SAMPLE; kills and cooldowns keep running.
- alive_count is combinational from the alive register.

## Timing
- Reset values: spawn_valid=0, spawn_index=0, spawn_x=0, spawn_y=0, alive=0, alive_count=0, all cooldowns 0, rr_ptr=NUM_SLOTS-1, FSM=IDLE, retry=0.
- Reset asserted mid-operation clears everything immediately (asynchronously), including a pending offer.
- Latency from IDLE with an eligible slot to spawn_valid=1 is 3 cycles when the first sample is in bounds. Each retry adds 2 cycles; the worst case is 3+2·MAX_RETRY.
- alive[slot] rises in the cycle after the handshake.
- A killed slot can respawn no earlier than after RESPAWN_FRAMES start_of_frame pulses following the kill.

## Structure
- Shared package corona_pkg holds:
  - NUM_CORONAS=10, COORD_W=11, IDX_W=4, NO_CORONA=4'hF;
  - play-area bounds;
  - the FSM state enum.
- Sub-module rr_slot_picker: combinational rotating-priority encoder. Inputs are the eligible vector and rr_ptr; outputs are found and index.

## Test plan
- Reset, then enable=1, rand_x=100, rand_y=200, spawn_ready=1 → spawn_valid in cycle 3 with index 0, (100,200). Slot 1 is not offered until after the next start_of_frame.
- All alive, kill slot 3 → alive[3]=0. No offer after 59 frames; slot 3 is offered after frame 60.
- rand_x held at 700, rand_y=200 → 8 samples (one initial plus MAX_RETRY retries), then offer x=575, y=200 at cycle 17.
- spawn_ready=0 for 20 cycles with enable dropped → spawn_valid stays high with data unchanged. The handshake completes when spawn_ready=1.
- kill_index=15, kill_index=10, and a kill of an already-dead slot mid-cooldown → no change to alive or the cooldown.
- reset pulsed while in OFFER → spawn_valid=0 and alive=0 the same cycle. The next offer after release is index 0.

Source files
------------

// File: rtl/corona_pkg.sv
// Shared constants, play-area bounds and FSM state type for the
// corona respawn path.
package corona_pkg;

    localparam int NUM_CORONAS = 10;
    localparam int COORD_W     = 11;
    localparam int IDX_W       = 4;

    localparam logic [IDX_W-1:0] NO_CORONA = 4'hF;

    localparam int RESPAWN_FRAMES_DEF = 60;
    localparam int MAX_RETRY_DEF      = 7;

    localparam logic [COORD_W-1:0] PLAY_X_MIN = 11'd32;
    localparam logic [COORD_W-1:0] PLAY_X_MAX = 11'd575;
    localparam logic [COORD_W-1:0] PLAY_Y_MIN = 11'd64;
    localparam logic [COORD_W-1:0] PLAY_Y_MAX = 11'd415;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_OFFER,
        ST_GAP
    } state_e;

    function automatic logic [COORD_W-1:0] clamp_coord(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/rr_slot_picker.sv
// Rotating-priority encoder: first set bit of i_eligible searching
// upward from (i_ptr+1) mod N.
module rr_slot_picker
    import corona_pkg::*;
#(
    parameter int N = NUM_CORONAS
) (
    input  logic [N-1:0]     i_eligible,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_index
);

    int               w_j;
    logic [IDX_W-1:0] w_jj;
    logic [N-1:0]     w_sh;

    // Walk from farthest to nearest so the nearest hit is assigned last.
    always_comb begin
        o_found = 1'b0;
        o_index = '0;
        w_j     = 0;
        w_jj    = '0;
        w_sh    = '0;
        for (int i = N; i >= 1; i--) begin
            w_j = int'(i_ptr) + i;
            if (w_j >= N) w_j = w_j - N;
            w_jj = IDX_W'(w_j);
            w_sh = i_eligible >> w_jj;
            if (w_sh[0]) begin
                o_found = 1'b1;
                o_index = w_jj;
            end
        end
    end

endmodule

// File: rtl/corona_spawn_scheduler.sv
// Tracks alive coronas and their respawn cooldowns, and offers at most
// one in-bounds respawn per video frame over a valid/ready handshake.
module corona_spawn_scheduler
    import corona_pkg::*;
#(
    parameter int                 NUM_SLOTS      = NUM_CORONAS,
    parameter int                 RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
    parameter int                 MAX_RETRY      = MAX_RETRY_DEF,
    parameter logic [COORD_W-1:0] X_MIN          = PLAY_X_MIN,
    parameter logic [COORD_W-1:0] X_MAX          = PLAY_X_MAX,
    parameter logic [COORD_W-1:0] Y_MIN          = PLAY_Y_MIN,
    parameter logic [COORD_W-1:0] Y_MAX          = PLAY_Y_MAX
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start_of_frame,
    input  logic                 i_enable,
    input  logic                 i_kill_valid,
    input  logic [IDX_W-1:0]     i_kill_index,
    input  logic [COORD_W-1:0]   i_rand_x,
    input  logic [COORD_W-1:0]   i_rand_y,
    input  logic                 i_spawn_ready,
    output logic                 o_spawn_valid,
    output logic [IDX_W-1:0]     o_spawn_index,
    output logic [COORD_W-1:0]   o_spawn_x,
    output logic [COORD_W-1:0]   o_spawn_y,
    output logic [NUM_SLOTS-1:0] o_alive,
    output logic [IDX_W-1:0]     o_alive_count
);

    localparam int CD_W = $clog2(RESPAWN_FRAMES + 1);
    localparam int RT_W = $clog2(MAX_RETRY + 1);
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(RESPAWN_FRAMES);
    localparam logic [RT_W-1:0]  RT_MAX  = RT_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(NUM_SLOTS - 1);

    state_e               r_state;
    state_e               w_next;
    logic [NUM_SLOTS-1:0] r_alive;
    logic [CD_W-1:0]      r_cd [NUM_SLOTS];
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [IDX_W-1:0]     r_slot;
    logic [RT_W-1:0]      r_retry;
    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;

    logic [NUM_SLOTS-1:0] w_eligible;
    logic                 w_found;
    logic [IDX_W-1:0]     w_pick;
    logic                 w_in_bounds;
    logic                 w_fire;
    logic                 w_start;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            w_eligible[i] = !r_alive[i] && (r_cd[i] == '0);
    end

    rr_slot_picker #(
        .N (NUM_SLOTS)
    ) u_picker (
        .i_eligible (w_eligible),
        .i_ptr      (r_rr_ptr),
        .o_found    (w_found),
        .o_index    (w_pick)
    );

    assign w_in_bounds = (r_x >= X_MIN) && (r_x <= X_MAX) &&
                         (r_y >= Y_MIN) && (r_y <= Y_MAX);
    assign w_fire  = (r_state == ST_OFFER) && i_spawn_ready;
    assign w_start = i_enable && w_found;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_SAMPLE;
            ST_SAMPLE: w_next = ST_CHECK;
            ST_CHECK:
                if (w_in_bounds || r_retry >= RT_MAX) w_next = ST_OFFER;
                else w_next = ST_SAMPLE;
            ST_OFFER:  if (i_spawn_ready) w_next = ST_GAP;
            ST_GAP:    if (i_start_of_frame) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_slot   <= '0;
            r_retry  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_rr_ptr <= PTR_RST;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE:
                    if (w_start) begin
                        r_slot  <= w_pick;
                        r_retry <= '0;
                    end
                ST_SAMPLE: begin
                    r_x <= i_rand_x;
                    r_y <= i_rand_y;
                end
                ST_CHECK:
                    if (!w_in_bounds) begin
                        if (r_retry < RT_MAX) begin
                            r_retry <= r_retry + 1'b1;
                        end else begin
                            r_x <= clamp_coord(r_x, X_MIN, X_MAX);
                            r_y <= clamp_coord(r_y, Y_MIN, Y_MAX);
                        end
                    end
                ST_OFFER:
                    if (i_spawn_ready) r_rr_ptr <= r_slot;
                default: ;
            endcase
        end
    end

    // Kills only hit alive slots, so a pending or cooling slot is never reloaded.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_alive <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) r_cd[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (i_kill_valid && i_kill_index == IDX_W'(i) && r_alive[i]) begin
                    r_alive[i] <= 1'b0;
                    r_cd[i]    <= CD_LOAD;
                end else begin
                    if (w_fire && r_slot == IDX_W'(i))
                        r_alive[i] <= 1'b1;
                    if (i_start_of_frame && !r_alive[i] && r_cd[i] != '0)
                        r_cd[i] <= r_cd[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        o_alive_count = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            o_alive_count = o_alive_count + IDX_W'(r_alive[i]);
    end

    assign o_spawn_valid = (r_state == ST_OFFER);
    assign o_spawn_index = r_slot;
    assign o_spawn_x     = r_x;
    assign o_spawn_y     = r_y;
    assign o_alive       = r_alive;

endmodule

// File: tb/tb_corona_spawn_scheduler.sv
// Directed bench for corona_spawn_scheduler: bounds/clamp table plus
// hand-written sequences for cooldown, stall, kill filtering and reset.
module tb_corona_spawn_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        sof;
    logic        en;
    logic        kv;
    logic [3:0]  ki;
    logic [10:0] rx;
    logic [10:0] ry;
    logic        rdy;
    logic        valid;
    logic [3:0]  idx;
    logic [10:0] sx;
    logic [10:0] sy;
    logic [9:0]  alive;
    logic [3:0]  acnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    corona_spawn_scheduler dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_start_of_frame (sof),
        .i_enable         (en),
        .i_kill_valid     (kv),
        .i_kill_index     (ki),
        .i_rand_x         (rx),
        .i_rand_y         (ry),
        .i_spawn_ready    (rdy),
        .o_spawn_valid    (valid),
        .o_spawn_index    (idx),
        .o_spawn_x        (sx),
        .o_spawn_y        (sy),
        .o_alive          (alive),
        .o_alive_count    (acnt)
    );

    typedef struct {
        int rx;
        int ry;
        int lat;
        int ex;
        int ey;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        sof = 1'b1;
        step();
        sof = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sof = 1'b0;
        en  = 1'b0;
        kv  = 1'b0;
        ki  = 4'hF;
        rx  = '0;
        ry  = '0;
        rdy = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int budget, output int n);
        n = 0;
        while (!valid && n < budget) begin
            step();
            n++;
        end
        if (!valid) begin
            errors++;
            checks++;
            $display("FAIL %s: no spawn_valid within %0d cycles", nm, budget);
        end
    endtask

    initial begin
        int  n;
        logic bad;

        tbl[0] = '{100,  200, 3,  100, 200};
        tbl[1] = '{700,  200, 17, 575, 200};
        tbl[2] = '{10,   200, 17, 32,  200};
        tbl[3] = '{100,  500, 17, 100, 415};
        tbl[4] = '{32,   64,  3,  32,  64};
        tbl[5] = '{575,  415, 3,  575, 415};
        tbl[6] = '{576,  63,  17, 575, 64};
        tbl[7] = '{2047, 0,   17, 575, 64};

        // reset state
        do_reset();
        check("rst_valid", int'(valid), 0);
        check("rst_index", int'(idx), 0);
        check("rst_x", int'(sx), 0);
        check("rst_y", int'(sy), 0);
        check("rst_alive", int'(alive), 0);
        check("rst_count", int'(acnt), 0);

        // bounds / retry / clamp table
        for (int k = 0; k < 8; k++) begin
            do_reset();
            rx = 11'(tbl[k].rx);
            ry = 11'(tbl[k].ry);
            en = 1'b1;
            wait_valid($sformatf("vec%0d_wait", k), 40, n);
            check($sformatf("vec%0d_lat", k), n, tbl[k].lat);
            check($sformatf("vec%0d_idx", k), int'(idx), 0);
            check($sformatf("vec%0d_x", k), int'(sx), tbl[k].ex);
            check($sformatf("vec%0d_y", k), int'(sy), tbl[k].ey);
        end

        // first spawn, one per frame, then fill every slot
        do_reset();
        rx  = 11'd100;
        ry  = 11'd200;
        rdy = 1'b1;
        en  = 1'b1;
        wait_valid("first_wait", 40, n);
        check("first_lat", n, 3);
        check("first_idx", int'(idx), 0);
        step();
        check("first_alive", int'(alive), 1);
        check("first_count", int'(acnt), 1);
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (valid) bad = 1'b1;
        end
        check("gap_no_offer", int'(bad), 0);
        frame();
        for (int k = 1; k < 10; k++) begin
            wait_valid($sformatf("fill%0d_wait", k), 40, n);
            check($sformatf("fill%0d_idx", k), int'(idx), k);
            step();
            frame();
        end
        check("full_alive", int'(alive), 10'h3FF);
        check("full_count", int'(acnt), 10);

        // kill filtering and cooldown
        kv = 1'b1;
        ki = 4'd3;
        step();
        check("kill3_alive", int'(alive), 10'h3F7);
        check("kill3_count", int'(acnt), 9);
        ki = 4'hF;
        step();
        ki = 4'd10;
        step();
        kv = 1'b0;
        check("illegal_kill", int'(alive), 10'h3F7);
        for (int f = 0; f < 30; f++) frame();
        kv = 1'b1;
        ki = 4'd3;
        step();
        kv = 1'b0;
        check("dead_kill", int'(alive), 10'h3F7);
        for (int f = 0; f < 29; f++) frame();
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (valid) bad = 1'b1;
        end
        check("cd59_no_offer", int'(bad), 0);
        sof = 1'b1;
        step();
        sof = 1'b0;
        check("cd60_edge", int'(valid), 0);
        wait_valid("cd60_wait", 40, n);
        check("cd60_lat", n, 3);
        check("cd60_idx", int'(idx), 3);
        step();
        check("respawn_alive", int'(alive), 10'h3FF);

        // stalled offer holds through enable drop
        do_reset();
        rx = 11'd100;
        ry = 11'd200;
        en = 1'b1;
        wait_valid("stall_wait", 40, n);
        en = 1'b0;
        rx = 11'd300;
        ry = 11'd300;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (!valid || idx != 4'd0 || sx != 11'd100 || sy != 11'd200)
                bad = 1'b1;
        end
        check("stall_hold", int'(bad), 0);
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        check("stall_done_valid", int'(valid), 0);
        check("stall_done_alive", int'(alive), 1);

        // asynchronous reset during a pending offer
        do_reset();
        rx  = 11'd100;
        ry  = 11'd200;
        rdy = 1'b1;
        en  = 1'b1;
        wait_valid("ar_wait0", 40, n);
        step();
        frame();
        rdy = 1'b0;
        wait_valid("ar_wait1", 40, n);
        check("ar_pre_idx", int'(idx), 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", int'(valid), 0);
        check("ar_alive", int'(alive), 0);
        check("ar_count", int'(acnt), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_valid("ar_wait2", 40, n);
        check("ar_next_lat", n, 3);
        check("ar_next_idx", int'(idx), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
